// File: rtl/regs_read_arbiter_if.sv
// Bundle between the operand-fetch side, the arbiter and the register file.
// The slave side is the arbiter; the master side is everything around it.
interface regs_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 4,
    parameter int DW      = 16
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ*DW-1:0] rsp_data;
    logic                  wr_valid;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;
    logic                  ren0;
    logic [AW-1:0]         raddr0;
    logic [DW-1:0]         rdata0;
    logic                  ren1;
    logic [AW-1:0]         raddr1;
    logic [DW-1:0]         rdata1;
    logic                  wen;
    logic [AW-1:0]         waddr;
    logic [DW-1:0]         wdata;

    modport slave (
        input  req_valid, req_addr, wr_valid, wr_addr, wr_data,
        input  rdata0, rdata1,
        output req_ready, rsp_valid, rsp_data,
        output ren0, raddr0, ren1, raddr1, wen, waddr, wdata
    );

    modport master (
        output req_valid, req_addr, wr_valid, wr_addr, wr_data,
        output rdata0, rdata1,
        input  req_ready, rsp_valid, rsp_data,
        input  ren0, raddr0, ren1, raddr1, wen, waddr, wdata
    );
endinterface

// File: rtl/regs_read_arbiter.sv
// Round-robin sharing of the two regfile read ports, with a 2-cycle
// response pipeline and same-cycle write forwarding.
module regs_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 4,
    parameter int DW      = 16
) (
    input  logic               clk,
    input  logic               reset,
    regs_read_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] r_ptr;

    logic          w_g0;
    logic          w_g1;
    logic [IW-1:0] w_i0;
    logic [IW-1:0] w_i1;
    logic [IW:0]   w_k;
    logic [IW-1:0] w_last;
    logic [IW:0]   w_nx;
    logic [AW-1:0] w_a0;
    logic [AW-1:0] w_a1;
    logic          w_f0;
    logic          w_f1;
    logic [DW-1:0] w_rd [2];

    logic [1:0]    r_v1;
    logic [1:0]    r_v2;
    logic [1:0]    r_f1;
    logic [1:0]    r_f2;
    logic [IW-1:0] r_i1 [2];
    logic [IW-1:0] r_i2 [2];
    logic [DW-1:0] r_d1 [2];
    logic [DW-1:0] r_d2 [2];

    // Scan from r_ptr with wrap; first two valid requesters win ports 0/1.
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        w_i0 = '0;
        w_i1 = '0;
        w_k  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_k >= (IW+1)'(NUM_REQ))
                w_k = w_k - (IW+1)'(NUM_REQ);
            if (bus.req_valid[w_k[IW-1:0]]) begin
                if (!w_g0) begin
                    w_g0 = 1'b1;
                    w_i0 = w_k[IW-1:0];
                end else if (!w_g1) begin
                    w_g1 = 1'b1;
                    w_i1 = w_k[IW-1:0];
                end
            end
        end
    end

    // Next pointer sits just past the last requester granted this cycle.
    always_comb begin
        w_last = w_g1 ? w_i1 : w_i0;
        w_nx   = {1'b0, w_last} + (IW+1)'(1);
        if (w_nx >= (IW+1)'(NUM_REQ))
            w_nx = '0;
    end

    assign w_a0  = bus.req_addr[w_i0*AW +: AW];
    assign w_a1  = bus.req_addr[w_i1*AW +: AW];
    // A write in the grant cycle lands after the regfile samples the address.
    assign w_f0  = bus.wr_valid && (bus.wr_addr == w_a0);
    assign w_f1  = bus.wr_valid && (bus.wr_addr == w_a1);
    assign w_rd[0] = bus.rdata0;
    assign w_rd[1] = bus.rdata1;

    // Grant vector, blanked while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (!reset) begin
            if (w_g0)
                bus.req_ready[w_i0] = 1'b1;
            if (w_g1)
                bus.req_ready[w_i1] = 1'b1;
        end
    end

    assign bus.ren0   = !reset && w_g0;
    assign bus.raddr0 = (!reset && w_g0) ? w_a0 : '0;
    assign bus.ren1   = !reset && w_g1;
    assign bus.raddr1 = (!reset && w_g1) ? w_a1 : '0;
    assign bus.wen    = !reset && bus.wr_valid;
    assign bus.waddr  = bus.wr_addr;
    assign bus.wdata  = bus.wr_data;

    // Rotation pointer and the two-deep tag pipeline for each read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_v1  <= '0;
            r_v2  <= '0;
            r_f1  <= '0;
            r_f2  <= '0;
            for (int p = 0; p < 2; p++) begin
                r_i1[p] <= '0;
                r_i2[p] <= '0;
                r_d1[p] <= '0;
                r_d2[p] <= '0;
            end
        end else begin
            if (w_g0)
                r_ptr <= w_nx[IW-1:0];
            r_v1    <= {w_g1, w_g0};
            r_f1    <= {w_f1, w_f0};
            r_i1[0] <= w_i0;
            r_i1[1] <= w_i1;
            r_d1[0] <= bus.wr_data;
            r_d1[1] <= bus.wr_data;
            r_v2    <= r_v1;
            r_f2    <= r_f1;
            for (int p = 0; p < 2; p++) begin
                r_i2[p] <= r_i1[p];
                r_d2[p] <= r_d1[p];
            end
        end
    end

    // Steer each returning read to its requester's slice.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                if (r_v2[p]) begin
                    bus.rsp_valid[r_i2[p]] = 1'b1;
                    bus.rsp_data[r_i2[p]*DW +: DW] =
                        r_f2[p] ? r_d2[p] : w_rd[p];
                end
            end
        end
    end
endmodule

// File: tb/tb_regs_read_arbiter.sv
// Directed bench for regs_read_arbiter with a 2-cycle regfile model.
// Inputs change at posedge+1, outputs are checked at posedge+2.
module tb_regs_read_arbiter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    regs_read_arbiter_if #(.NUM_REQ(4), .AW(4), .DW(16)) bus ();

    regs_read_arbiter #(.NUM_REQ(4), .AW(4), .DW(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [16];
    logic [15:0] q0a, q0b, q1a, q1b;

    // Register file: address sampled at the edge, data two cycles later.
    always @(posedge clk) begin
        q0a <= mem[bus.raddr0];
        q0b <= q0a;
        q1a <= mem[bus.raddr1];
        q1b <= q1a;
        if (bus.wen)
            mem[bus.waddr] <= bus.wdata;
    end

    assign bus.rdata0 = q0b;
    assign bus.rdata1 = q1b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [3:0] v, input logic [15:0] a,
                       input logic wv, input logic [3:0] wa,
                       input logic [15:0] wd);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.wr_valid  = wv;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        #1;
    endtask

    function automatic logic [15:0] d(input int i);
        return bus.rsp_data[i*16 +: 16];
    endfunction

    logic [3:0] e_rdy;
    logic [3:0] e_rsp;

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        reset = 1'b1;
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        step();
        // reset state with live inputs
        drv(4'b1111, 16'h7653, 1'b1, 4'h2, 16'h5555);
        chk("rst_ready", bus.req_ready, 4'b0000);
        chk("rst_ren0", bus.ren0, 1'b0);
        chk("rst_ren1", bus.ren1, 1'b0);
        chk("rst_raddr0", bus.raddr0, 4'h0);
        chk("rst_raddr1", bus.raddr1, 4'h0);
        chk("rst_wen", bus.wen, 1'b0);
        chk("rst_rsp", bus.rsp_valid, 4'b0000);
        step();
        reset = 1'b0;
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);

        // preload through the write port
        step();
        drv(4'b0000, 16'h0, 1'b1, 4'h3, 16'h1234);
        chk("wr_wen", bus.wen, 1'b1);
        chk("wr_waddr", bus.waddr, 4'h3);
        chk("wr_wdata", bus.wdata, 16'h1234);
        step();
        drv(4'b0000, 16'h0, 1'b1, 4'h5, 16'h1111);
        step();
        drv(4'b0000, 16'h0, 1'b1, 4'h6, 16'h6666);
        step();
        drv(4'b0000, 16'h0, 1'b1, 4'h7, 16'h7777);
        step();
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);

        // single read, exact 2-cycle latency
        step();
        drv(4'b0001, 16'h0003, 1'b0, 4'h0, 16'h0);
        chk("t1_ready", bus.req_ready, 4'b0001);
        chk("t1_ren0", bus.ren0, 1'b1);
        chk("t1_raddr0", bus.raddr0, 4'h3);
        chk("t1_ren1", bus.ren1, 1'b0);
        chk("t1_raddr1", bus.raddr1, 4'h0);
        step();
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        chk("t1_rsp_c1", bus.rsp_valid, 4'b0000);
        step();
        chk("t1_rsp_c2", bus.rsp_valid, 4'b0001);
        chk("t1_data", d(0), 16'h1234);
        step();
        chk("t1_rsp_c3", bus.rsp_valid, 4'b0000);

        // move pointer back to 0 via requester 3
        step();
        drv(4'b1000, 16'h3000, 1'b0, 4'h0, 16'h0);
        chk("p3_ready", bus.req_ready, 4'b1000);
        step();
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        step();
        chk("p3_rsp", bus.rsp_valid, 4'b1000);
        chk("p3_data", d(3), 16'h1234);

        // two grants per cycle, rotation from ptr=0
        step();
        drv(4'b1110, 16'h7650, 1'b0, 4'h0, 16'h0);
        chk("t2_rdy_c", bus.req_ready, 4'b0110);
        chk("t2_raddr0_c", bus.raddr0, 4'h5);
        chk("t2_raddr1_c", bus.raddr1, 4'h6);
        chk("t2_ren1_c", bus.ren1, 1'b1);
        step();
        chk("t2_rdy_c1", bus.req_ready, 4'b1010);
        chk("t2_raddr0_c1", bus.raddr0, 4'h7);
        chk("t2_raddr1_c1", bus.raddr1, 4'h5);
        step();
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        chk("t2_rsp_c2", bus.rsp_valid, 4'b0110);
        chk("t2_d1_c2", d(1), 16'h1111);
        chk("t2_d2_c2", d(2), 16'h6666);
        step();
        chk("t2_rsp_c3", bus.rsp_valid, 4'b1010);
        chk("t2_d3_c3", d(3), 16'h7777);
        chk("t2_d1_c3", d(1), 16'h1111);

        // all four requesting continuously, ptr=2
        for (int k = 0; k < 6; k++) begin
            step();
            if (k < 4)
                drv(4'b1111, 16'h7653, 1'b0, 4'h0, 16'h0);
            else
                drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
            e_rdy = (k >= 4) ? 4'b0000 : ((k % 2 == 0) ? 4'b1100 : 4'b0011);
            e_rsp = (k < 2) ? 4'b0000 : ((k % 2 == 0) ? 4'b1100 : 4'b0011);
            chk($sformatf("t3_rdy%0d", k), bus.req_ready, e_rdy);
            chk($sformatf("t3_rsp%0d", k), bus.rsp_valid, e_rsp);
            if (e_rsp == 4'b1100) begin
                chk($sformatf("t3_d2_%0d", k), d(2), 16'h6666);
                chk($sformatf("t3_d3_%0d", k), d(3), 16'h7777);
            end else if (e_rsp == 4'b0011) begin
                chk($sformatf("t3_d0_%0d", k), d(0), 16'h1234);
                chk($sformatf("t3_d1_%0d", k), d(1), 16'h1111);
            end
        end

        // same-cycle write forwarding on port 0 only
        step();
        drv(4'b0011, 16'h0065, 1'b1, 4'h5, 16'hBEEF);
        chk("t4_ready", bus.req_ready, 4'b0011);
        chk("t4_raddr0", bus.raddr0, 4'h5);
        chk("t4_raddr1", bus.raddr1, 4'h6);
        step();
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        step();
        chk("t4_rsp", bus.rsp_valid, 4'b0011);
        chk("t4_fwd_d0", d(0), 16'hBEEF);
        chk("t4_old_d1", d(1), 16'h6666);

        // both ports read the address being written
        step();
        drv(4'b0011, 16'h0066, 1'b1, 4'h6, 16'hABCD);
        step();
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        step();
        chk("t4b_rsp", bus.rsp_valid, 4'b0011);
        chk("t4b_d0", d(0), 16'hABCD);
        chk("t4b_d1", d(1), 16'hABCD);

        // write one cycle before the read comes from the regfile
        step();
        drv(4'b0000, 16'h0, 1'b1, 4'h7, 16'h00AA);
        step();
        drv(4'b0001, 16'h0007, 1'b0, 4'h0, 16'h0);
        chk("t5_ready", bus.req_ready, 4'b0001);
        step();
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        step();
        chk("t5_rsp", bus.rsp_valid, 4'b0001);
        chk("t5_d0", d(0), 16'h00AA);
        step();

        // reset while a read is in flight (ptr=1 here)
        step();
        drv(4'b0100, 16'h0300, 1'b0, 4'h0, 16'h0);
        chk("t6_ready", bus.req_ready, 4'b0100);
        step();
        reset = 1'b1;
        drv(4'b1111, 16'h7653, 1'b1, 4'h1, 16'h0);
        chk("t6_rst_rdy", bus.req_ready, 4'b0000);
        chk("t6_rst_ren0", bus.ren0, 1'b0);
        chk("t6_rst_raddr0", bus.raddr0, 4'h0);
        chk("t6_rst_wen", bus.wen, 1'b0);
        step();
        reset = 1'b0;
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        chk("t6_no_rsp", bus.rsp_valid, 4'b0000);
        step();
        drv(4'b1010, 16'h7050, 1'b0, 4'h0, 16'h0);
        chk("t6_ptr0_rdy", bus.req_ready, 4'b1010);
        chk("t6_raddr0", bus.raddr0, 4'h5);
        chk("t6_raddr1", bus.raddr1, 4'h7);
        step();
        drv(4'b0000, 16'h0, 1'b0, 4'h0, 16'h0);
        chk("t6_rsp_c1", bus.rsp_valid, 4'b0000);
        step();
        chk("t6_rsp_c2", bus.rsp_valid, 4'b1010);
        chk("t6_d1", d(1), 16'hBEEF);
        chk("t6_d3", d(3), 16'h00AA);
        step();
        chk("t6_rsp_c3", bus.rsp_valid, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
